mem_access_ctrl: RTL and testbench

//  - MEM-stage sequencer between the EX/MEM pipeline register and a variable-latency data memory (req/ack).
//  - Launches one LW/SW per instruction and stalls the pipeline (including EX/MEM hold) until memory acks.
//  - Returns load data plus destination register to the writeback path.

---
 rtl/mem_ctrl_pkg.sv | 14 +
 rtl/mem_access_ctrl_if.sv | 32 +++
 rtl/mem_timeout_cnt.sv | 26 ++
 rtl/mem_access_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizes for the MEM-stage access controller.
package mem_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int DATA_W_DEFAULT      = 16;
    localparam int ADDR_W_DEFAULT      = 16;
    localparam int RD_W_DEFAULT        = 4;
    localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/ack data-memory bus between the MEM-stage controller (master) and the memory (slave).
interface mem_access_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_timeout_cnt.sv
// Counts BUSY cycles without ack; expired flags the last allowed cycle (used with MEM_TIMEOUT_EN).
module mem_timeout_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] limit,
    output logic        expired
);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 16'd1;
        end
    end

    // Gated by en, so an ack in the limit cycle (which drops en) wins over the timeout.
    assign expired = en && (count == limit - 16'd1);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: one req/ack memory access per LW/SW, stalling the pipeline until ack.
// Optional access timeout with mem_err pulse when MEM_TIMEOUT_EN is defined.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int RD_W        = RD_W_DEFAULT,
    parameter int TIMEOUT_CYC = MEM_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_to_reg,
    input  logic              reg_to_mem,
    input  logic [RD_W-1:0]   reg_rd,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] save_word,
    output logic              stall,
    mem_access_ctrl_if.master mem,
    output logic              wb_valid,
    output logic [RD_W-1:0]   wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_err
);

    state_t            state;
    state_t            next_state;
    logic              access;
    logic              timeout;
    logic [RD_W-1:0]   rd_q;

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYC out of range 1..65535");
    end

    assign access = mem_to_reg | reg_to_mem;

`ifdef MEM_TIMEOUT_EN
    logic tmo_expired;

    mem_timeout_cnt u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == IDLE),
        .en      ((state == BUSY) && !mem.mem_ack),
        .limit   (16'(TIMEOUT_CYC)),
        .expired (tmo_expired)
    );

    assign timeout = tmo_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= timeout;
        end
    end
`else
    assign timeout = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (access) next_state = BUSY;
            BUSY:    if (mem.mem_ack || timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Stall drops in the ack (or timeout) cycle so EX/MEM advances on that edge.
    always_comb begin
        stall = 1'b0;
        case (state)
            IDLE:    stall = access;
            BUSY:    stall = !mem.mem_ack && !timeout;
            default: stall = 1'b0;
        endcase
    end

    // Store wins when both request bits are set; rdata is only captured for loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            rd_q          <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (state == IDLE && access) begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= reg_to_mem;
                mem.mem_addr  <= alu_result[ADDR_W-1:0];
                mem.mem_wdata <= save_word;
                rd_q          <= reg_rd;
            end else if (state == BUSY && (mem.mem_ack || timeout)) begin
                mem.mem_req <= 1'b0;
                if (mem.mem_ack && !mem.mem_we) begin
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    wb_data  <= mem.mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl; build with MEM_TIMEOUT_EN to run the timeout scenario.
module tb_mem_access_ctrl;
    import mem_ctrl_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int RW = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = MEM_TIMEOUT_DEFAULT;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_to_reg;
    logic          reg_to_mem;
    logic [RW-1:0] reg_rd;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] save_word;
    logic          stall;
    logic          wb_valid;
    logic [RW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          mem_err;

    int checks = 0;
    int passed = 0;

    mem_access_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) mem_bus ();

    mem_access_ctrl #(
        .DATA_W      (DW),
        .ADDR_W      (AW),
        .RD_W        (RW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_to_reg (mem_to_reg),
        .reg_to_mem (reg_to_mem),
        .reg_rd     (reg_rd),
        .alu_result (alu_result),
        .save_word  (save_word),
        .stall      (stall),
        .mem        (mem_bus),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    // Called on a falling edge with the controller idle; plays memory with ack in request cycle ack_at
    // and returns on the falling edge after the ack, with the request bits cleared.
    task automatic run_access(input logic ld, input logic st, input logic [RW-1:0] rd,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input int ack_at, input logic [DW-1:0] rdata,
                              output int occ, output int launches, output int stall_bad,
                              output logic we_seen, output logic [AW-1:0] addr_seen,
                              output logic [DW-1:0] wdata_seen);
        int   req_cyc;
        logic prev_req;
        bit   done;
        mem_to_reg = ld;
        reg_to_mem = st;
        reg_rd = rd;
        alu_result = addr;
        save_word = wdata;
        mem_bus.mem_ack = 1'b0;
        #1;
        occ = 1;
        launches = 0;
        stall_bad = (stall !== 1'b1) ? 1 : 0;
        req_cyc = 0;
        prev_req = mem_bus.mem_req;
        done = 1'b0;
        we_seen = 1'bx;
        addr_seen = 'x;
        wdata_seen = 'x;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            occ++;
            if (mem_bus.mem_req === 1'b1) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    we_seen = mem_bus.mem_we;
                    addr_seen = mem_bus.mem_addr;
                    wdata_seen = mem_bus.mem_wdata;
                end
                if (prev_req !== 1'b1) launches++;
            end
            prev_req = mem_bus.mem_req;
            mem_bus.mem_ack = (mem_bus.mem_req === 1'b1) && (req_cyc == ack_at);
            mem_bus.mem_rdata = rdata;
            #1;
            if (stall !== !mem_bus.mem_ack) stall_bad++;
            if (stall === 1'b0) done = 1'b1;
        end
        if (!done) occ = -1;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        mem_to_reg = 1'b0;
        reg_to_mem = 1'b0;
        if (mem_bus.mem_req === 1'b1) launches++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_to_reg = 1'b0;
        reg_to_mem = 1'b0;
        reg_rd = '0;
        alu_result = '0;
        save_word = '0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) $display("[TB] FAIL reset_stall: got %0h expected 0", stall); else passed++;
        checks++; if (mem_bus.mem_req !== 1'b0) $display("[TB] FAIL reset_mem_req: got %0h expected 0", mem_bus.mem_req); else passed++;
        checks++; if (mem_bus.mem_we !== 1'b0) $display("[TB] FAIL reset_mem_we: got %0h expected 0", mem_bus.mem_we); else passed++;
        checks++; if (mem_bus.mem_addr !== 16'h0) $display("[TB] FAIL reset_mem_addr: got %0h expected 0", mem_bus.mem_addr); else passed++;
        checks++; if (mem_bus.mem_wdata !== 16'h0) $display("[TB] FAIL reset_mem_wdata: got %0h expected 0", mem_bus.mem_wdata); else passed++;
        checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL reset_wb_valid: got %0h expected 0", wb_valid); else passed++;
        checks++; if (wb_rd !== 4'h0) $display("[TB] FAIL reset_wb_rd: got %0h expected 0", wb_rd); else passed++;
        checks++; if (wb_data !== 16'h0) $display("[TB] FAIL reset_wb_data: got %0h expected 0", wb_data); else passed++;
        checks++; if (mem_err !== 1'b0) $display("[TB] FAIL reset_mem_err: got %0h expected 0", mem_err); else passed++;
    endtask

    task automatic test_load();
        int occ, lc, sb;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        run_access(1'b1, 1'b0, 4'd5, 16'h0040, 16'h0000, 3, 16'hBEEF, occ, lc, sb, we, a, d);
        #1;
        checks++; if (occ !== 4) $display("[TB] FAIL lw_mem_occupancy: got %0d expected 4", occ); else passed++;
        checks++; if (sb !== 0) $display("[TB] FAIL lw_stall_pattern: got %0d bad cycles expected 0", sb); else passed++;
        checks++; if (lc !== 1) $display("[TB] FAIL lw_launches: got %0d expected 1", lc); else passed++;
        checks++; if (we !== 1'b0) $display("[TB] FAIL lw_mem_we: got %0h expected 0", we); else passed++;
        checks++; if (a !== 16'h0040) $display("[TB] FAIL lw_mem_addr: got %0h expected 40", a); else passed++;
        checks++; if (wb_valid !== 1'b1) $display("[TB] FAIL lw_wb_valid: got %0h expected 1", wb_valid); else passed++;
        checks++; if (wb_rd !== 4'd5) $display("[TB] FAIL lw_wb_rd: got %0h expected 5", wb_rd); else passed++;
        checks++; if (wb_data !== 16'hBEEF) $display("[TB] FAIL lw_wb_data: got %0h expected beef", wb_data); else passed++;
        @(negedge clk);
        #1;
        checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL lw_wb_pulse: got %0h expected 0", wb_valid); else passed++;
        checks++; if (wb_data !== 16'hBEEF) $display("[TB] FAIL lw_wb_hold: got %0h expected beef", wb_data); else passed++;
    endtask

    task automatic test_store();
        int occ, lc, sb;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        run_access(1'b0, 1'b1, 4'd3, 16'h0010, 16'h1234, 1, 16'hDEAD, occ, lc, sb, we, a, d);
        #1;
        checks++; if (occ !== 2) $display("[TB] FAIL sw_mem_occupancy: got %0d expected 2", occ); else passed++;
        checks++; if (sb !== 0) $display("[TB] FAIL sw_stall_pattern: got %0d bad cycles expected 0", sb); else passed++;
        checks++; if (we !== 1'b1) $display("[TB] FAIL sw_mem_we: got %0h expected 1", we); else passed++;
        checks++; if (a !== 16'h0010) $display("[TB] FAIL sw_mem_addr: got %0h expected 10", a); else passed++;
        checks++; if (d !== 16'h1234) $display("[TB] FAIL sw_mem_wdata: got %0h expected 1234", d); else passed++;
        checks++; if (lc !== 1) $display("[TB] FAIL sw_launches: got %0d expected 1", lc); else passed++;
        checks++; if (wb_valid !== 1'b0) $display("[TB] FAIL sw_no_wb_valid: got %0h expected 0", wb_valid); else passed++;
        checks++; if (wb_data !== 16'hBEEF) $display("[TB] FAIL sw_wb_data_kept: got %0h expected beef", wb_data); else passed++;
    endtask

    task automatic test_back_to_back();
        int occ1, lc1, sb1, occ2, lc2, sb2;
        logic we1, we2;
        logic [AW-1:0] a1, a2;
        logic [DW-1:0] d1, d2;
        run_access(1'b1, 1'b0, 4'd7, 16'h0080, 16'h0000, 1, 16'hCAFE, occ1, lc1, sb1, we1, a1, d1);
        #1;
        checks++; if (mem_bus.mem_req !== 1'b0) $display("[TB] FAIL b2b_idle_gap: got %0h expected 0", mem_bus.mem_req); else passed++;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 16'hCAFE) $display("[TB] FAIL b2b_lw_wb: got %0h/%0h expected 1/cafe", wb_valid, wb_data); else passed++;
        run_access(1'b0, 1'b1, 4'd1, 16'h0090, 16'h5A5A, 1, 16'h0000, occ2, lc2, sb2, we2, a2, d2);
        #1;
        checks++; if (occ1 !== 2 || occ2 !== 2) $display("[TB] FAIL b2b_occupancy: got %0d/%0d expected 2/2", occ1, occ2); else passed++;
        checks++; if (lc1 !== 1 || lc2 !== 1) $display("[TB] FAIL b2b_launches: got %0d/%0d expected 1/1", lc1, lc2); else passed++;
        checks++; if (sb1 !== 0 || sb2 !== 0) $display("[TB] FAIL b2b_stall_pattern: got %0d/%0d expected 0/0", sb1, sb2); else passed++;
        checks++; if (we1 !== 1'b0 || a1 !== 16'h0080) $display("[TB] FAIL b2b_first_lw: got we=%0h addr=%0h expected 0/80", we1, a1); else passed++;
        checks++; if (we2 !== 1'b1 || a2 !== 16'h0090 || d2 !== 16'h5A5A) $display("[TB] FAIL b2b_second_sw: got we=%0h addr=%0h data=%0h expected 1/90/5a5a", we2, a2, d2); else passed++;
        checks++; if (wb_valid !== 1'b0 || wb_rd !== 4'd7) $display("[TB] FAIL b2b_sw_no_wb: got %0h/%0h expected 0/7", wb_valid, wb_rd); else passed++;
    endtask

    task automatic test_both_and_spurious();
        int occ, lc, sb;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        mem_bus.mem_ack = 1'b1;
        mem_bus.mem_rdata = 16'hFFFF;
        #1;
        checks++; if (stall !== 1'b0) $display("[TB] FAIL spurious_ack_stall: got %0h expected 0", stall); else passed++;
        @(negedge clk);
        mem_bus.mem_ack = 1'b0;
        #1;
        checks++; if (mem_bus.mem_req !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 16'hCAFE) $display("[TB] FAIL spurious_ack_ignored: got req=%0h wbv=%0h data=%0h expected 0/0/cafe", mem_bus.mem_req, wb_valid, wb_data); else passed++;
        run_access(1'b1, 1'b1, 4'd9, 16'h0020, 16'hABCD, 2, 16'h1111, occ, lc, sb, we, a, d);
        #1;
        checks++; if (we !== 1'b1 || d !== 16'hABCD) $display("[TB] FAIL both_store_priority: got we=%0h data=%0h expected 1/abcd", we, d); else passed++;
        checks++; if (occ !== 3 || lc !== 1) $display("[TB] FAIL both_occupancy: got %0d/%0d expected 3/1", occ, lc); else passed++;
        checks++; if (wb_valid !== 1'b0 || wb_rd !== 4'd7) $display("[TB] FAIL both_no_wb: got %0h/%0h expected 0/7", wb_valid, wb_rd); else passed++;
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int busy_cyc = 0;
        int err_cnt = 0;
        int wbv_cnt = 0;
        bit released = 1'b0;
        mem_to_reg = 1'b1;
        reg_rd = 4'd4;
        alu_result = 16'h0066;
        for (int i = 0; i < 20 && !released; i++) begin
            @(negedge clk);
            #1;
            busy_cyc++;
            if (stall === 1'b0) released = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_to_reg = 1'b0;
            #1;
            if (i == 0 && mem_bus.mem_req !== 1'b0) err_cnt += 100;
            if (mem_err === 1'b1) err_cnt++;
            if (wb_valid === 1'b1) wbv_cnt++;
        end
        checks++; if (!released || busy_cyc !== TMO) $display("[TB] FAIL timeout_release_cycle: got %0d expected %0d", busy_cyc, TMO); else passed++;
        checks++; if (err_cnt !== 1) $display("[TB] FAIL timeout_mem_err_pulse: got %0d expected 1", err_cnt); else passed++;
        checks++; if (wbv_cnt !== 0) $display("[TB] FAIL timeout_no_wb_valid: got %0d expected 0", wbv_cnt); else passed++;
    endtask
`else
    task automatic test_no_timeout();
        int occ, lc, sb;
        logic we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        run_access(1'b1, 1'b0, 4'd6, 16'h0070, 16'h0000, 9, 16'h7777, occ, lc, sb, we, a, d);
        #1;
        checks++; if (occ !== 10 || sb !== 0) $display("[TB] FAIL slow_ack_wait: got occ=%0d bad=%0d expected 10/0", occ, sb); else passed++;
        checks++; if (mem_err !== 1'b0) $display("[TB] FAIL slow_ack_mem_err: got %0h expected 0", mem_err); else passed++;
        checks++; if (wb_valid !== 1'b1 || wb_data !== 16'h7777 || wb_rd !== 4'd6) $display("[TB] FAIL slow_ack_wb: got %0h/%0h/%0h expected 1/7777/6", wb_valid, wb_data, wb_rd); else passed++;
    endtask
`endif

    task automatic test_async_reset();
        int busy_bad = 0;
        mem_to_reg = 1'b1;
        reg_rd = 4'd2;
        alu_result = 16'h0044;
        mem_bus.mem_ack = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            if (mem_bus.mem_req !== 1'b1 || stall !== 1'b1) busy_bad++;
        end
        checks++; if (busy_bad !== 0) $display("[TB] FAIL rst_busy_before: got %0d bad cycles expected 0", busy_bad); else passed++;
        @(negedge clk);
        mem_to_reg = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) $display("[TB] FAIL rst_busy_stall: got %0h expected 1", stall); else passed++;
        #1;
        rst = 1'b1;
        #1;
        checks++; if (mem_bus.mem_req !== 1'b0 || stall !== 1'b0) $display("[TB] FAIL rst_async_drop: got req=%0h stall=%0h expected 0/0", mem_bus.mem_req, stall); else passed++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0 || mem_bus.mem_req !== 1'b0) $display("[TB] FAIL rst_idle_after: got stall=%0h req=%0h expected 0/0", stall, mem_bus.mem_req); else passed++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_back_to_back();
        test_both_and_spurious();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
